wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 113 +++++++++++
 tb/tb_wb_arbiter2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with alternating tie-break, outstanding tracking and a stall/ack watchdog.
module wb_arbiter2 #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_sel,
  output logic        o_m0_stall,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_sel,
  output logic        o_m1_stall,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d, to_q, to_d;
  logic [1:0]  own_q, own_d, blk_q, blk_d;
  logic [4:0]  out_q, out_d;
  logic [9:0]  wd_q, wd_d;
  logic        g0, g1, live0, live1, cyc_own, acc, inc, fire, req0, req1;

  assign g0    = state_q == GNT0;
  assign g1    = state_q == GNT1;
  // Bus drive is cut the moment reset is seen so an aborted cycle never reaches the slave again.
  assign live0 = g0 && i_reset_n;
  assign live1 = g1 && i_reset_n;

  assign o_wb_cyc  = live0 ? i_m0_cyc : live1 && i_m1_cyc;
  assign o_wb_stb  = live0 ? i_m0_stb : live1 && i_m1_stb;
  assign o_wb_we   = live0 ? i_m0_we  : live1 && i_m1_we;
  assign o_wb_addr = g1 ? i_m1_addr : i_m0_addr;
  assign o_wb_data = g1 ? i_m1_data : i_m0_data;
  assign o_wb_sel  = g1 ? i_m1_sel  : i_m0_sel;

  assign o_m0_data  = i_wb_data;
  assign o_m1_data  = i_wb_data;
  assign o_m0_stall = !live0 || i_wb_stall;
  assign o_m1_stall = !live1 || i_wb_stall;
  assign o_m0_ack   = live0 && i_wb_ack;
  assign o_m1_ack   = live1 && i_wb_ack;
  // A watchdog abort reports its error to the former owner while the FSM already sits in IDLE.
  assign o_m0_err   = (live0 && i_wb_err) || (i_reset_n && to_q && own_q[0]);
  assign o_m1_err   = (live1 && i_wb_err) || (i_reset_n && to_q && own_q[1]);
  assign o_grant    = state_q;
  assign o_timeout  = to_q;

  assign cyc_own = g1 ? i_m1_cyc : i_m0_cyc;
  assign acc     = o_wb_stb && !i_wb_stall;
  assign inc     = (g0 || g1) && !i_wb_ack && !i_wb_err &&
                   ((o_wb_stb && i_wb_stall) || out_q != 5'd0);
  assign fire    = inc && wd_q == 10'(TIMEOUT - 1);
  assign req0    = i_m0_cyc && !blk_q[0];
  assign req1    = i_m1_cyc && !blk_q[1];

  always_comb begin
    state_d = state_q == IDLE ? (req0 && req1 ? (last_q ? GNT0 : GNT1) :
                                 req0 ? GNT0 : req1 ? GNT1 : IDLE)
                              : (fire || !cyc_own ? IDLE : state_q);
    last_d  = state_q == IDLE && state_d != IDLE ? state_d == GNT1 : last_q;
    blk_d   = (blk_q & {i_m1_cyc, i_m0_cyc}) | (fire ? {g1, g0} : 2'b00);
    to_d    = fire;
    own_d   = {g1, g0};
    out_d   = state_d == IDLE ? 5'd0 :
              acc && !i_wb_ack && out_q != 5'd31 ? out_q + 5'd1 :
              i_wb_ack && !acc && out_q != 5'd0 ? out_q - 5'd1 : out_q;
    wd_d    = state_d == IDLE || !inc ? 10'd0 : wd_q + 10'd1;
  end

  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      to_q    <= 1'b0;
      own_q   <= 2'b00;
      blk_q   <= 2'b00;
      out_q   <= 5'd0;
      wd_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      to_q    <= to_d;
      own_q   <= own_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      wd_q    <= wd_d;
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios; expected grant/ack/err/timeout events are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_wb_arbiter2;
  logic        i_clk = 1'b0, i_reset_n;
  logic        i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we;
  logic [29:0] i_m0_addr, i_m1_addr;
  logic [31:0] i_m0_data, i_m1_data, i_wb_data;
  logic [3:0]  i_m0_sel, i_m1_sel;
  logic        o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_data, o_m1_data, o_wb_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_stall, i_wb_ack, i_wb_err;
  logic [29:0] o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [1:0]  o_grant;
  logic        o_timeout;

  wb_arbiter2 #(.TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel), .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack),
    .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel), .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack),
    .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .i_wb_data(i_wb_data), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [1:0]  g;
    logic        a0, e0, a1, e1, to, wc, ws;
    logic [29:0] wa;
    logic [31:0] d;
    int          o;
  } ev_t;

  ev_t        q[$];
  ev_t        e;
  int         cnt = 0, tests = 0, fails = 0, c;
  logic       mon_en = 1'b0, ok;
  logic [1:0] pg;

  always @(posedge i_clk) cnt <= cnt + 1;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp(input int cy, input logic [1:0] g, input logic a0, e0, a1, e1, to, wc, ws,
                     input logic [29:0] wa, input logic [31:0] d, input int o);
    ev_t x;
    x.cyc = cy; x.g = g; x.a0 = a0; x.e0 = e0; x.a1 = a1; x.e1 = e1; x.to = to;
    x.wc = wc; x.ws = ws; x.wa = wa; x.d = d; x.o = o;
    q.push_back(x);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Monitor: bus invariants every cycle, and one scoreboard pop per observed event.
  always @(negedge i_clk) if (mon_en) begin
    tests++;
    ok = (o_grant == 2'b01 || (o_m0_stall && !o_m0_ack)) &&
         (o_grant == 2'b10 || (o_m1_stall && !o_m1_ack)) &&
         (o_grant != 2'b00 || (!o_wb_cyc && !o_wb_stb)) &&
         o_m0_data == i_wb_data && o_m1_data == i_wb_data;
    if (!ok) begin
      fails++;
      $display("FAIL invariant cyc=%0d grant=%b stall=%b%b ack=%b%b wb_cyc=%b wb_stb=%b",
               cnt, o_grant, o_m1_stall, o_m0_stall, o_m1_ack, o_m0_ack, o_wb_cyc, o_wb_stb);
    end
    if (o_grant != pg || o_m0_ack || o_m0_err || o_m1_ack || o_m1_err || o_timeout) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d grant=%b ack=%b%b err=%b%b timeout=%b",
                 cnt, o_grant, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err, o_timeout);
      end else begin
        e = q.pop_front();
        ok = e.cyc == cnt && o_grant == e.g && o_m0_ack == e.a0 && o_m0_err == e.e0 &&
             o_m1_ack == e.a1 && o_m1_err == e.e1 && o_timeout == e.to &&
             o_wb_cyc == e.wc && o_wb_stb == e.ws && (!e.ws || o_wb_addr == e.wa) &&
             (!(e.a0 || e.a1) || o_m0_data == e.d) && (e.o < 0 || dut.out_q == 5'(e.o));
        if (!ok) begin
          fails++;
          $display("FAIL event got cyc=%0d g=%b a=%b%b e=%b%b to=%b wc=%b ws=%b wa=%h d=%h out=%0d expected cyc=%0d g=%b a=%b%b e=%b%b to=%b wc=%b ws=%b wa=%h d=%h out=%0d",
                   cnt, o_grant, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err, o_timeout, o_wb_cyc,
                   o_wb_stb, o_wb_addr, o_m0_data, dut.out_q,
                   e.cyc, e.g, e.a1, e.a0, e.e1, e.e0, e.to, e.wc, e.ws, e.wa, e.d, e.o);
        end
      end
    end
    pg = o_grant;
  end

  initial begin
    i_reset_n = 1'b0;
    {i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we} = '0;
    {i_m0_addr, i_m1_addr, i_m0_data, i_m1_data, i_wb_data} = '0;
    i_m0_sel = 4'hf; i_m1_sel = 4'hf;
    {i_wb_stall, i_wb_ack, i_wb_err} = '0;
    tick; tick;
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_wb_ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we}), 0);
    chk("rst_stall", 32'({o_m1_stall, o_m0_stall}), 3);
    chk("rst_ack_err", 32'({o_m1_ack, o_m0_ack, o_m1_err, o_m0_err}), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    pg = o_grant; mon_en = 1'b1;
    i_reset_n = 1'b1;
    // M0 single read, slave acks two cycles after acceptance
    tick; c = cnt;
    exp(c + 1, 2'b01, 0, 0, 0, 0, 0, 1, 1, 30'h5, 0, -1);
    exp(c + 3, 2'b01, 1, 0, 0, 0, 0, 1, 0, 0, 32'h11, -1);
    exp(c + 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h5;
    tick;
    tick; i_m0_stb = 0;
    tick; i_wb_ack = 1; i_wb_data = 32'h11;
    tick; i_wb_ack = 0; i_wb_data = 0; i_m0_cyc = 0;
    tick; tick;
    // tie after reset: M0, idle gap, M1, then a second tie goes to M0
    i_reset_n = 0; tick; i_reset_n = 1;
    tick; c = cnt;
    exp(c + 1, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    exp(c + 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    exp(c + 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    exp(c + 6, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    exp(c + 7, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    exp(c + 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    i_m0_cyc = 1; i_m1_cyc = 1;
    tick;
    tick; i_m0_cyc = 0;
    tick;
    tick;
    tick; i_m1_cyc = 0;
    tick; i_m0_cyc = 1; i_m1_cyc = 1;
    tick;
    tick; i_m0_cyc = 0; i_m1_cyc = 0;
    tick; tick;
    // M1 pipelined reads; first ack coincides with a new strobe
    tick; c = cnt;
    exp(c + 1, 2'b10, 0, 0, 0, 0, 0, 1, 1, 30'h10, 0, 0);
    exp(c + 4, 2'b10, 0, 0, 1, 0, 0, 1, 1, 30'h13, 32'ha0, 3);
    exp(c + 5, 2'b10, 0, 0, 1, 0, 0, 1, 0, 0, 32'ha1, 3);
    exp(c + 6, 2'b10, 0, 0, 1, 0, 0, 1, 0, 0, 32'ha2, 2);
    exp(c + 7, 2'b10, 0, 0, 1, 0, 0, 1, 0, 0, 32'ha3, 1);
    exp(c + 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 30'h10;
    tick;
    tick; i_m1_addr = 30'h11;
    tick; i_m1_addr = 30'h12;
    tick; i_m1_addr = 30'h13; i_wb_ack = 1; i_wb_data = 32'ha0;
    tick; i_m1_stb = 0; i_wb_data = 32'ha1;
    tick; i_wb_data = 32'ha2;
    tick; i_wb_data = 32'ha3;
    tick; i_wb_ack = 0; i_wb_data = 0; i_m1_cyc = 0;
    tick; tick;
    // M0 write never acked: watchdog abort, no regrant until cyc seen low
    tick; c = cnt;
    exp(c + 1, 2'b01, 0, 0, 0, 0, 0, 1, 1, 30'h20, 0, -1);
    exp(c + 10, 2'b00, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    exp(c + 17, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    exp(c + 19, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 30'h20; i_m0_data = 32'hdeadbeef;
    tick;
    tick; i_m0_stb = 0;
    repeat (13) tick;
    i_m0_cyc = 0;
    tick; i_m0_cyc = 1;
    tick;
    tick; i_m0_cyc = 0; i_m0_we = 0;
    tick; tick;
    // slave error on M1 read: forwarded, grant held until cyc drops
    tick; c = cnt;
    exp(c + 1, 2'b10, 0, 0, 0, 0, 0, 1, 1, 30'h30, 0, -1);
    exp(c + 3, 2'b10, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    exp(c + 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 30'h30;
    tick;
    tick; i_m1_stb = 0;
    tick; i_wb_err = 1;
    tick; i_wb_err = 0;
    tick;
    tick; i_m1_cyc = 0;
    tick; tick;
    // reset during an outstanding M0 read; late ack must not surface
    tick; c = cnt;
    exp(c + 1, 2'b01, 0, 0, 0, 0, 0, 1, 1, 30'h40, 0, -1);
    exp(c + 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h40;
    tick;
    tick; i_m0_stb = 0; i_reset_n = 0;
    tick; i_reset_n = 1; i_m0_cyc = 0;
    tick; i_wb_ack = 1; i_wb_data = 32'h55;
    tick; i_wb_ack = 0; i_wb_data = 0;
    tick; tick; tick;
    chk("events_pending", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
